// File: rtl/spmm_pkg.sv
// Shared constants, state encoding and helpers for the CSR SpMM engine.
package spmm_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_MAX_NNZ = 16;
    localparam int DEF_IDX_W   = 4;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ROW_INIT = 3'd1;
    localparam logic [2:0] S_A_FETCH  = 3'd2;
    localparam logic [2:0] S_B_SCAN   = 3'd3;
    localparam logic [2:0] S_COMPACT  = 3'd4;
    localparam logic [2:0] S_ROW_END  = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    function automatic int max_dim(input int idx_w);
        return 2 ** idx_w;
    endfunction

    function automatic int ptr_w(input int max_nnz);
        return $clog2(max_nnz + 1);
    endfunction

    // Signed saturation bounds for a w-bit element.
    function automatic logic signed [127:0] sat_hi(input int w);
        return (128'sd1 <<< (w - 1)) - 128'sd1;
    endfunction

    function automatic logic signed [127:0] sat_lo(input int w);
        return -(128'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/spmm_mac.sv
// Combinational accumulate of acc + a*b.
// SPMM_SAT_EN selects signed saturation; otherwise modulo-2^DATA_W wrap.
module spmm_mac
    import spmm_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] acc_o
);

`ifdef SPMM_SAT_EN
    localparam int WW = 2 * DATA_W + 1;
    localparam logic signed [WW-1:0] HI = WW'(sat_hi(DATA_W));
    localparam logic signed [WW-1:0] LO = WW'(sat_lo(DATA_W));

    function automatic logic [DATA_W-1:0] clamp(input logic signed [WW-1:0] v);
        if (v > HI) return HI[DATA_W-1:0];
        if (v < LO) return LO[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    logic signed [WW-1:0] prod_w;
    logic signed [WW-1:0] sum_w;
    logic [DATA_W-1:0]    prod_s;

    always_comb begin
        prod_w = WW'($signed(a_i)) * WW'($signed(b_i));
        prod_s = clamp(prod_w);
        sum_w  = WW'($signed(acc_i)) + WW'($signed(prod_s));
        acc_o  = clamp(sum_w);
    end
`else
    assign acc_o = acc_i + a_i * b_i;
`endif

endmodule

// File: rtl/spmm_csr_engine.sv
// Row-wise (Gustavson) CSR sparse x sparse multiply, C = A*B.
// Build with SPMM_SAT_EN for saturating MAC arithmetic.
module spmm_csr_engine
    import spmm_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_NNZ = DEF_MAX_NNZ,
    parameter int IDX_W   = DEF_IDX_W,
    localparam int MAX_DIM = max_dim(IDX_W),
    localparam int PTR_W   = ptr_w(MAX_NNZ)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic [IDX_W:0]                 rows_A_i,
    input  logic [IDX_W:0]                 cols_B_i,
    input  logic [MAX_NNZ-1:0][DATA_W-1:0] NVA_i,
    input  logic [MAX_NNZ-1:0][DATA_W-1:0] NVB_i,
    input  logic [MAX_NNZ-1:0][IDX_W-1:0]  CIA_i,
    input  logic [MAX_NNZ-1:0][IDX_W-1:0]  CIB_i,
    input  logic [MAX_DIM:0][PTR_W-1:0]    RPA_i,
    input  logic [MAX_DIM:0][PTR_W-1:0]    RPB_i,
    output logic [MAX_NNZ-1:0][DATA_W-1:0] NVC_o,
    output logic [MAX_NNZ-1:0][IDX_W-1:0]  CIC_o,
    output logic [MAX_DIM:0][PTR_W-1:0]    RPC_o,
    output logic [PTR_W-1:0]               nnz_C_o,
    output logic                           computing_o,
    output logic                           op_complete_o,
    output logic                           overflow_o
);

    localparam int NI = $clog2(MAX_NNZ);
    localparam int RW = IDX_W + 1;
    localparam logic [RW-1:0]    DIM_MAX = RW'(MAX_DIM);
    localparam logic [PTR_W-1:0] CAP     = PTR_W'(MAX_NNZ);

    state_t                         state_q, state_d;
    logic [RW-1:0]                  r_q, r_d;
    logic [RW-1:0]                  col_q, col_d;
    logic [PTR_W-1:0]               k_q, k_d;
    logic [PTR_W-1:0]               kend_q, kend_d;
    logic [PTR_W-1:0]               p_q, p_d;
    logic [PTR_W-1:0]               pend_q, pend_d;
    logic [PTR_W-1:0]               wr_q, wr_d;
    logic [DATA_W-1:0]              a_q, a_d;
    logic [MAX_DIM-1:0][DATA_W-1:0] acc_q, acc_d;
    logic [MAX_NNZ-1:0][DATA_W-1:0] nvc_q, nvc_d;
    logic [MAX_NNZ-1:0][IDX_W-1:0]  cic_q, cic_d;
    logic [MAX_DIM:0][PTR_W-1:0]    rpc_q, rpc_d;
    logic [PTR_W-1:0]               nnz_q, nnz_d;
    logic                           ovf_q, ovf_d;
    logic                           done_q, done_d;

    logic [RW-1:0]     rows, cols, r_nx, col_nx, jr, jr_nx;
    logic [PTR_W-1:0]  k_nx, p_nx, wr_nx, pb, pbe;
    logic [IDX_W-1:0]  cb;
    logic [DATA_W-1:0] cv, mac_out;
    state_t            row_tail;

    assign rows   = (rows_A_i > DIM_MAX) ? DIM_MAX : rows_A_i;
    assign cols   = (cols_B_i > DIM_MAX) ? DIM_MAX : cols_B_i;
    assign r_nx   = r_q + RW'(1);
    assign col_nx = col_q + RW'(1);
    assign k_nx   = k_q + PTR_W'(1);
    assign p_nx   = p_q + PTR_W'(1);
    assign wr_nx  = wr_q + PTR_W'(1);
    assign jr     = {1'b0, CIA_i[k_q[NI-1:0]]};
    assign jr_nx  = jr + RW'(1);
    assign pb     = RPB_i[jr];
    assign pbe    = RPB_i[jr_nx];
    assign cb     = CIB_i[p_q[NI-1:0]];
    assign cv     = acc_q[col_q[IDX_W-1:0]];
    // A zero-column C skips the compaction scan entirely.
    assign row_tail = (cols == '0) ? S_ROW_END : S_COMPACT;

    spmm_mac #(.DATA_W(DATA_W)) u_mac (
        .acc_i (acc_q[cb]),
        .a_i   (a_q),
        .b_i   (NVB_i[p_q[NI-1:0]]),
        .acc_o (mac_out)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        col_d   = col_q;
        k_d     = k_q;
        kend_d  = kend_q;
        p_d     = p_q;
        pend_d  = pend_q;
        wr_d    = wr_q;
        a_d     = a_q;
        acc_d   = acc_q;
        nvc_d   = nvc_q;
        cic_d   = cic_q;
        rpc_d   = rpc_q;
        nnz_d   = nnz_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    nvc_d   = '0;
                    cic_d   = '0;
                    rpc_d   = '0;
                    nnz_d   = '0;
                    ovf_d   = 1'b0;
                    wr_d    = '0;
                    r_d     = '0;
                    state_d = (rows == '0) ? S_DONE : S_ROW_INIT;
                end
            end
            S_ROW_INIT: begin
                acc_d   = '0;
                col_d   = '0;
                k_d     = RPA_i[r_q];
                kend_d  = RPA_i[r_nx];
                state_d = (RPA_i[r_q] < RPA_i[r_nx]) ? S_A_FETCH : row_tail;
            end
            S_A_FETCH: begin
                a_d    = NVA_i[k_q[NI-1:0]];
                p_d    = pb;
                pend_d = pbe;
                if (pb < pbe) begin
                    state_d = S_B_SCAN;
                end else begin
                    k_d     = k_nx;
                    state_d = (k_nx < kend_q) ? S_A_FETCH : row_tail;
                end
            end
            S_B_SCAN: begin
                acc_d[cb] = mac_out;
                p_d       = p_nx;
                if (p_nx >= pend_q) begin
                    k_d     = k_nx;
                    state_d = (k_nx < kend_q) ? S_A_FETCH : row_tail;
                end
            end
            S_COMPACT: begin
                if (cv != '0) begin
                    if (wr_q < CAP) begin
                        nvc_d[wr_q[NI-1:0]] = cv;
                        cic_d[wr_q[NI-1:0]] = col_q[IDX_W-1:0];
                        wr_d                = wr_nx;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                col_d = col_nx;
                if (col_nx >= cols) state_d = S_ROW_END;
            end
            S_ROW_END: begin
                rpc_d[r_nx] = wr_q;
                r_d         = r_nx;
                state_d     = (r_nx >= rows) ? S_DONE : S_ROW_INIT;
            end
            S_DONE: begin
                nnz_d   = wr_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            col_q   <= '0;
            k_q     <= '0;
            kend_q  <= '0;
            p_q     <= '0;
            pend_q  <= '0;
            wr_q    <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            nvc_q   <= '0;
            cic_q   <= '0;
            rpc_q   <= '0;
            nnz_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            col_q   <= col_d;
            k_q     <= k_d;
            kend_q  <= kend_d;
            p_q     <= p_d;
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            nvc_q   <= nvc_d;
            cic_q   <= cic_d;
            rpc_q   <= rpc_d;
            nnz_q   <= nnz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign NVC_o         = nvc_q;
    assign CIC_o         = cic_q;
    assign RPC_o         = rpc_q;
    assign nnz_C_o       = nnz_q;
    assign overflow_o    = ovf_q;
    assign op_complete_o = done_q;
    assign computing_o   = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule
